// File: rtl/nd_2to1_arb_pkg.sv
// Shared types and defaults for the 2-to-1 message merger.
// State encodings, size defaults and the round-robin pick helper.
package nd_2to1_arb_pkg;

   localparam logic NS_ON  = 1'b1;
   localparam logic NS_OFF = 1'b0;

   localparam int NS_MESSAGE_FIFO_SIZE = 4;
   localparam int NS_ADDRESS_SIZE      = 8;
   localparam int NS_DATA_SIZE         = 8;

   typedef enum logic [1:0] {
      NS_ARB_IDLE     = 2'd0,
      NS_ARB_WAIT_ACK = 2'd1,
      NS_ARB_WAIT_REL = 2'd2
   } arb_state_e;

   // 1 selects FIFO 1; on a tie the side not granted last wins
   function automatic logic rr_pick(
      input logic ne0,
      input logic ne1,
      input logic last
   );
      logic pick;
      pick = NS_OFF;
      if (ne0 && ne1) begin
         pick = ~last;
      end else if (ne1) begin
         pick = NS_ON;
      end
      return pick;
   endfunction

endpackage

// File: rtl/nd_2to1_arb_if.sv
// 4-phase request/acknowledge message channel.
// The master owns the message and req; the slave owns ack.
interface nd_chan_if
   import nd_2to1_arb_pkg::*;
#(
   parameter int ASZ = NS_ADDRESS_SIZE,
   parameter int DSZ = NS_DATA_SIZE
);

   logic [ASZ-1:0] src;
   logic [ASZ-1:0] dst;
   logic [DSZ-1:0] dat;
   logic           req;
   logic           ack;

   modport master (
      output src,
      output dst,
      output dat,
      output req,
      input  ack
   );

   modport slave (
      input  src,
      input  dst,
      input  dat,
      input  req,
      output ack
   );

endinterface

// File: rtl/nd_2to1_arb_fifo.sv
// Per-input message FIFO with occupancy count.
// Pointers wrap modulo FSZ; the count is one bit wider.
module nd_msg_fifo
   import nd_2to1_arb_pkg::*;
#(
   parameter int FSZ = NS_MESSAGE_FIFO_SIZE,
   parameter int ASZ = NS_ADDRESS_SIZE,
   parameter int DSZ = NS_DATA_SIZE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic [2*ASZ+DSZ-1:0] push_msg,
   input  logic                 pop,
   output logic                 full,
   output logic                 empty,
   output logic [2*ASZ+DSZ-1:0] head
);

   localparam int MSZ = 2*ASZ + DSZ;
   localparam int PW  = $clog2(FSZ);

   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
   localparam logic [PW:0]   CNT_MAX = (PW+1)'(FSZ);

   logic [MSZ-1:0] mem_q [FSZ];

   logic [PW-1:0] wptr_q;
   logic [PW-1:0] wptr_d;
   logic [PW-1:0] rptr_q;
   logic [PW-1:0] rptr_d;
   logic [PW:0]   cnt_q;
   logic [PW:0]   cnt_d;

   logic do_push;
   logic do_pop;

   assign full  = (cnt_q == CNT_MAX);
   assign empty = (cnt_q == '0);
   assign head  = mem_q[rptr_q];

   always_comb begin
      do_push = push && !full;
      do_pop  = pop && !empty;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      cnt_d   = cnt_q;
      if (do_push) begin
         wptr_d = wptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rptr_d = rptr_q + PTR_ONE;
      end
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage needs no reset: the count alone decides what is valid
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q] <= push_msg;
      end
   end

endmodule

// File: rtl/nd_2to1_arb.sv
// Two-input message merger: per-input FIFOs feeding one
// outbound 4-phase channel under round-robin arbitration.
module nd_2to1_arb
   import nd_2to1_arb_pkg::*;
#(
   parameter int FSZ = NS_MESSAGE_FIFO_SIZE,
   parameter int ASZ = NS_ADDRESS_SIZE,
   parameter int DSZ = NS_DATA_SIZE
) (
   input  logic      i_clk,
   input  logic      reset,
   output logic      ready,
   nd_chan_if.slave  rcv0,
   nd_chan_if.slave  rcv1,
   nd_chan_if.master snd0
);

   localparam int MSZ = 2*ASZ + DSZ;

   logic       ready_q;
   logic       ready_d;
   logic       ack0_q;
   logic       ack0_d;
   logic       ack1_q;
   logic       ack1_d;
   logic       req_q;
   logic       req_d;
   logic       last_q;
   logic       last_d;
   arb_state_e state_q;
   arb_state_e state_d;

   logic [MSZ-1:0] msg_q;
   logic [MSZ-1:0] msg_d;

   logic           push0;
   logic           push1;
   logic           pop0;
   logic           pop1;
   logic           full0;
   logic           full1;
   logic           empty0;
   logic           empty1;
   logic           gnt1;
   logic [MSZ-1:0] in0;
   logic [MSZ-1:0] in1;
   logic [MSZ-1:0] head0;
   logic [MSZ-1:0] head1;

   assign in0 = {rcv0.src, rcv0.dst, rcv0.dat};
   assign in1 = {rcv1.src, rcv1.dst, rcv1.dat};

   nd_msg_fifo #(
      .FSZ (FSZ),
      .ASZ (ASZ),
      .DSZ (DSZ)
   ) u_fifo0 (
      .clk      (i_clk),
      .rst_n    (reset),
      .push     (push0),
      .push_msg (in0),
      .pop      (pop0),
      .full     (full0),
      .empty    (empty0),
      .head     (head0)
   );

   nd_msg_fifo #(
      .FSZ (FSZ),
      .ASZ (ASZ),
      .DSZ (DSZ)
   ) u_fifo1 (
      .clk      (i_clk),
      .rst_n    (reset),
      .push     (push1),
      .push_msg (in1),
      .pop      (pop1),
      .full     (full1),
      .empty    (empty1),
      .head     (head1)
   );

   always_comb begin
      ready_d = NS_ON;
      ack0_d  = ack0_q;
      ack1_d  = ack1_q;
      req_d   = req_q;
      last_d  = last_q;
      state_d = state_q;
      msg_d   = msg_q;
      push0   = NS_OFF;
      push1   = NS_OFF;
      pop0    = NS_OFF;
      pop1    = NS_OFF;
      gnt1    = rr_pick(!empty0, !empty1, last_q);

      // The first cycle out of reset only raises ready
      if (ready_q) begin
         unique case (1'b1)
            (rcv0.req && !ack0_q && !full0): begin
               push0  = NS_ON;
               ack0_d = NS_ON;
            end
            (!rcv0.req && ack0_q): ack0_d = NS_OFF;
            default: ;
         endcase

         unique case (1'b1)
            (rcv1.req && !ack1_q && !full1): begin
               push1  = NS_ON;
               ack1_d = NS_ON;
            end
            (!rcv1.req && ack1_q): ack1_d = NS_OFF;
            default: ;
         endcase

         unique case (state_q)
            NS_ARB_IDLE: begin
               if (!empty0 || !empty1) begin
                  pop0    = !gnt1;
                  pop1    = gnt1;
                  msg_d   = gnt1 ? head1 : head0;
                  last_d  = gnt1;
                  req_d   = NS_ON;
                  state_d = NS_ARB_WAIT_ACK;
               end
            end
            NS_ARB_WAIT_ACK: begin
               if (snd0.ack) begin
                  req_d   = NS_OFF;
                  state_d = NS_ARB_WAIT_REL;
               end
            end
            NS_ARB_WAIT_REL: begin
               if (!snd0.ack) begin
                  state_d = NS_ARB_IDLE;
               end
            end
            default: state_d = NS_ARB_IDLE;
         endcase
      end
   end

   // last_q resets to 1 so FIFO 0 wins the first tie
   always_ff @(posedge i_clk) begin
      if (!reset) begin
         ready_q <= NS_OFF;
         ack0_q  <= NS_OFF;
         ack1_q  <= NS_OFF;
         req_q   <= NS_OFF;
         last_q  <= NS_ON;
         state_q <= NS_ARB_IDLE;
         msg_q   <= '0;
      end else begin
         ready_q <= ready_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         req_q   <= req_d;
         last_q  <= last_d;
         state_q <= state_d;
         msg_q   <= msg_d;
      end
   end

   assign ready    = ready_q;
   assign rcv0.ack = ack0_q;
   assign rcv1.ack = ack1_q;
   assign snd0.req = req_q;
   assign {snd0.src, snd0.dst, snd0.dat} = msg_q;

endmodule
